// File: rtl/rs_loader_pkg.sv
// rtl/rs_loader_pkg.sv - shared widths and FSM state type for the RS_RAM8 loader
package rs_loader_pkg;
  localparam int RS_WORD_W = 8;
  localparam int RS_ADDR_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DRAIN} loader_state_t;
endpackage

// File: rtl/rs_ram8_port_mux.sv
// rtl/rs_ram8_port_mux.sv - RAM port select between loader and core
// The core only sees the RAM while the loader is idle; otherwise its writes vanish and it reads zero.
module rs_ram8_port_mux
  import rs_loader_pkg::*;
(
  input  logic                 sel_loader,
  input  logic [RS_ADDR_W-1:0] ldr_addr,
  input  logic [RS_WORD_W-1:0] ldr_di,
  input  logic                 ldr_we,
  input  logic [RS_ADDR_W-1:0] core_addr,
  input  logic [RS_WORD_W-1:0] core_di,
  input  logic                 core_we,
  input  logic [RS_WORD_W-1:0] ram_do,
  output logic [RS_ADDR_W-1:0] ram_addr,
  output logic [RS_WORD_W-1:0] ram_di,
  output logic                 ram_we,
  output logic [RS_WORD_W-1:0] core_do
);
  always_comb begin
    ram_addr = core_addr;
    ram_di   = core_di;
    ram_we   = core_we;
    core_do  = ram_do;
    if (sel_loader) begin
      ram_addr = ldr_addr;
      ram_di   = ldr_di;
      ram_we   = ldr_we;
      core_do  = '0;
    end
  end
endmodule

// File: rtl/rs_ram8_loader.sv
// rtl/rs_ram8_loader.sv - streams DEPTH bytes into RS_RAM8, reads them back and checks the sum
module rs_ram8_loader
  import rs_loader_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RS_WORD_W-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [RS_ADDR_W-1:0] ram_addr,
  output logic [RS_WORD_W-1:0] ram_di,
  output logic                 ram_we,
  input  logic [RS_WORD_W-1:0] ram_do,
  input  logic [RS_ADDR_W-1:0] core_addr,
  input  logic [RS_WORD_W-1:0] core_di,
  input  logic                 core_we,
  output logic [RS_WORD_W-1:0] core_do,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [RS_WORD_W-1:0] sum
);
  localparam logic [RS_ADDR_W-1:0] LAST = RS_ADDR_W'(DEPTH - 1);
  localparam logic [RS_ADDR_W-1:0] BASE = RS_ADDR_W'(START_ADDR);

  loader_state_t        state;
  logic [RS_ADDR_W-1:0] cnt;
  logic [RS_WORD_W-1:0] rsum;
  logic [RS_WORD_W-1:0] final_sum;
  logic [RS_ADDR_W-1:0] ldr_addr;
  logic                 ldr_we;

  // Address arithmetic is 8-bit so regions running past 0xFF wrap to 0x00.
  assign ldr_addr  = BASE + cnt;
  assign ldr_we    = (state == LOAD) && s_valid;
  assign s_ready   = (state == LOAD);
  assign busy      = (state != IDLE);
  assign final_sum = rsum + ram_do;

  rs_ram8_port_mux u_mux (
    .sel_loader (busy),
    .ldr_addr   (ldr_addr),
    .ldr_di     (s_data),
    .ldr_we     (ldr_we),
    .core_addr  (core_addr),
    .core_di    (core_di),
    .core_we    (core_we),
    .ram_do     (ram_do),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_we     (ram_we),
    .core_do    (core_do)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sum   <= '0;
      rsum  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done  <= 1'b0;
            err   <= 1'b0;
            sum   <= '0;
            rsum  <= '0;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            sum <= sum + s_data;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= VERIFY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        VERIFY: begin
          // RAM read data lags the address by one cycle, so the first cycle has nothing to add.
          if (cnt != '0) rsum <= rsum + ram_do;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DRAIN;
        end
        DRAIN: begin
          rsum  <= final_sum;
          err   <= (final_sum != sum);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_ram8_loader.sv
// tb/tb_rs_ram8_loader.sv - randomized self-checking bench for rs_ram8_loader
module tb_rs_ram8_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance A: DEPTH=4, START_ADDR=0
  logic       start_a = 0, s_valid_a = 0, core_we_a = 0;
  logic [7:0] s_data_a = 0, core_addr_a = 0, core_di_a = 0;
  logic       s_ready_a, ram_we_a, busy_a, done_a, err_a;
  logic [7:0] ram_addr_a, ram_di_a, ram_do_a, core_do_a, sum_a;
  logic [7:0] mem_a [256];
  logic       corrupt = 0;

  // instance B: DEPTH=3, START_ADDR=0xFE
  logic       start_b = 0, s_valid_b = 0;
  logic [7:0] s_data_b = 0;
  logic       s_ready_b, ram_we_b, busy_b, done_b, err_b;
  logic [7:0] ram_addr_b, ram_di_b, ram_do_b, core_do_b, sum_b;
  logic [7:0] mem_b [256];

  rs_ram8_loader #(.DEPTH(4), .START_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s_data(s_data_a), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .ram_addr(ram_addr_a), .ram_di(ram_di_a), .ram_we(ram_we_a),
    .ram_do(ram_do_a), .core_addr(core_addr_a), .core_di(core_di_a), .core_we(core_we_a),
    .core_do(core_do_a), .busy(busy_a), .done(done_a), .err(err_a), .sum(sum_a));

  rs_ram8_loader #(.DEPTH(3), .START_ADDR(8'hFE)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .ram_addr(ram_addr_b), .ram_di(ram_di_b), .ram_we(ram_we_b),
    .ram_do(ram_do_b), .core_addr(8'h00), .core_di(8'h00), .core_we(1'b0),
    .core_do(core_do_b), .busy(busy_b), .done(done_b), .err(err_b), .sum(sum_b));

  // RS_RAM8 models: registered read, optional read-back fault at address 1
  always @(posedge clk) begin
    if (ram_we_a) mem_a[ram_addr_a] <= ram_di_a;
    ram_do_a <= mem_a[ram_addr_a] ^ ((corrupt && ram_addr_a == 8'h01) ? 8'h01 : 8'h00);
    if (ram_we_b) mem_b[ram_addr_b] <= ram_di_b;
    ram_do_b <= mem_b[ram_addr_b];
  end

  // Drives one DEPTH=4 load on instance A; cycle 0 is the START cycle.
  task automatic do_load(input logic [7:0] d [4], input bit stall, input bit poke,
                         input bit restart, output int done_cyc, output int load_cyc);
    int idx = 0;
    done_cyc = -1;
    load_cyc = 0;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      s_valid_a = (idx < 4) && (!stall || (c % 2 == 1));
      s_data_a  = 8'h00;
      if (s_valid_a) s_data_a = d[idx];
      core_we_a   = poke && (idx < 4);
      core_addr_a = 8'h02;
      core_di_a   = 8'h5A;
      start_a     = restart && (c == 2 || c == 6);
      @(negedge clk);
      if (s_ready_a) load_cyc++;
      checks++;
      if (ram_we_a !== s_valid_a) begin
        errors++;
        $display("FAIL ram_we cyc=%0d got=%b want=%b", c, ram_we_a, s_valid_a);
      end
      if (s_valid_a) begin
        checks++;
        if (ram_addr_a !== 8'(idx) || ram_di_a !== d[idx]) begin
          errors++;
          $display("FAIL wr_port cyc=%0d got=%h/%h want=%h/%h", c, ram_addr_a, ram_di_a, 8'(idx), d[idx]);
        end
      end
      if (poke && busy_a) begin
        checks++;
        if (core_do_a !== 8'h00) begin
          errors++;
          $display("FAIL core_do_busy cyc=%0d got=%h want=00", c, core_do_a);
        end
      end
      if (done_a === 1'b1) done_cyc = c;
      if (s_valid_a) idx++;
      @(posedge clk); #1;
    end
    s_valid_a = 0;
    core_we_a = 0;
    start_a   = 0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout got=none want=done");
    end
  endtask

  task automatic check_result_a(input string tag, input logic [7:0] d [4], input bit exp_err);
    logic [7:0] exp_sum = 8'(d[0] + d[1] + d[2] + d[3]);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_a[i] !== d[i]) begin
        errors++;
        $display("FAIL %s mem[%0d] got=%h want=%h", tag, i, mem_a[i], d[i]);
      end
    end
    checks++;
    if (sum_a !== exp_sum || done_a !== 1'b1 || err_a !== exp_err || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL %s status got sum=%h done=%b err=%b busy=%b want sum=%h done=1 err=%b busy=0",
               tag, sum_a, done_a, err_a, busy_a, exp_sum, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 0 || done_a !== 0 || err_a !== 0 || sum_a !== 0 || s_ready_a !== 0 || ram_we_a !== 0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b err=%b sum=%h rdy=%b we=%b want all 0",
               busy_a, done_a, err_a, sum_a, s_ready_a, ram_we_a);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [7:0] a = 8'($urandom_range(16, 200));
    logic [7:0] v = 8'($urandom);
    core_addr_a = a; core_di_a = v; core_we_a = 1;
    #1;
    checks++;
    if (ram_addr_a !== a || ram_di_a !== v || ram_we_a !== 1'b1) begin
      errors++;
      $display("FAIL passthrough got=%h/%h/%b want=%h/%h/1", ram_addr_a, ram_di_a, ram_we_a, a, v);
    end
    @(posedge clk); #1;
    core_we_a = 0;
    @(posedge clk); #1;
    checks++;
    if (core_do_a !== v) begin
      errors++;
      $display("FAIL core_read got=%h want=%h", core_do_a, v);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d [4];
    int dc, lc;
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(d, 0, 0, 0, dc, lc);
    checks++;
    if (dc != 10 || lc != 4) begin
      errors++;
      $display("FAIL basic_timing got done=%0d load=%0d want done=10 load=4", dc, lc);
    end
    check_result_a("basic", d, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      do_load(d, 0, 0, r == 1, dc, lc);
      checks++;
      if (dc != 10) begin
        errors++;
        $display("FAIL rand_timing run=%0d got=%0d want=10", r, dc);
      end
      check_result_a("rand", d, 0);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d [4];
    int dc, lc;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    do_load(d, 1, 0, 0, dc, lc);
    checks++;
    if (lc != 7 || dc != 13) begin
      errors++;
      $display("FAIL stall_timing got load=%0d done=%0d want load=7 done=13", lc, dc);
    end
    check_result_a("stall", d, 0);
  endtask

  task automatic test_checksum_fault();
    logic [7:0] d [4];
    int dc, lc;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    corrupt = 1;
    do_load(d, 0, 0, 0, dc, lc);
    corrupt = 0;
    check_result_a("csum_fault", d, 1);
  endtask

  task automatic test_core_lockout();
    logic [7:0] d [4];
    int dc, lc;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    d[2] = 8'h33;
    do_load(d, 0, 1, 0, dc, lc);
    check_result_a("lockout", d, 0);
    core_addr_a = 8'h02; core_di_a = 8'h5A; core_we_a = 1;
    @(posedge clk); #1;
    core_we_a = 0;
    @(posedge clk); #1;
    checks++;
    if (mem_a[2] !== 8'h5A || core_do_a !== 8'h5A) begin
      errors++;
      $display("FAIL idle_core_write got mem=%h do=%h want 5a", mem_a[2], core_do_a);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] d [4];
    int dc, lc;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    s_valid_a = 1;
    for (int i = 0; i < 2; i++) begin
      s_data_a = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    s_data_a = 8'h77;
    #1 rst = 1;
    #1;
    checks++;
    if (busy_a !== 0 || s_ready_a !== 0 || done_a !== 0 || sum_a !== 0 || ram_we_a !== 0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b rdy=%b done=%b sum=%h we=%b want all 0",
               busy_a, s_ready_a, done_a, sum_a, ram_we_a);
    end
    s_valid_a = 0;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 0) begin
      errors++;
      $display("FAIL start_vs_rst got busy=%b want 0", busy_a);
    end
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    do_load(d, 0, 0, 0, dc, lc);
    checks++;
    if (dc != 10) begin
      errors++;
      $display("FAIL reload_timing got=%0d want=10", dc);
    end
    check_result_a("reload", d, 0);
  endtask

  task automatic test_wrap(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    logic [7:0] wa [$];
    logic [7:0] want_a [3];
    int idx = 0, dc = -1;
    d = '{d0, d1, d2};
    want_a = '{8'hFE, 8'hFF, 8'h00};
    start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      s_valid_b = (idx < 3);
      s_data_b  = 8'h00;
      if (s_valid_b) s_data_b = d[idx];
      @(negedge clk);
      if (ram_we_b) wa.push_back(ram_addr_b);
      if (done_b === 1'b1) dc = c;
      if (s_valid_b) idx++;
      @(posedge clk); #1;
    end
    s_valid_b = 0;
    checks++;
    if (wa.size() != 3 || dc != 8) begin
      errors++;
      $display("FAIL wrap_writes got n=%0d done=%0d want n=3 done=8", wa.size(), dc);
    end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== want_a[i] || mem_b[want_a[i]] !== d[i]) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got=%h/%h want=%h/%h", i, wa[i], mem_b[want_a[i]], want_a[i], d[i]);
      end
    end
    checks++;
    if (sum_b !== 8'(d0 + d1 + d2) || err_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sum got=%h err=%b want=%h err=0", sum_b, err_b, 8'(d0 + d1 + d2));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_basic();
    test_stall();
    test_checksum_fault();
    test_core_lockout();
    test_wrap(8'hAA, 8'hBB, 8'hCC);
    test_wrap(8'($urandom), 8'($urandom), 8'($urandom));
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
